xps2_ctrl: RTL

- Sequencer between the raw PS/2 byte receiver (xps2) and the controller data bus.
- Decodes scan-code set 2 prefix sequences (E0, F0, E1 pause) into single key events {ext, brk, code}.
- Buffers events in a FIFO and exposes them through a memory-mapped event / status / control window.
- Replaces the direct ps2 data/done wiring at PS2_BASE and frees firmware from prefix tracking.

---
 rtl/xps2_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/xps2_ctrl.sv
// PS/2 scan-code set 2 sequencer: folds E0/F0/E1 prefix runs into single key events,
// queues them in a FIFO and exposes event/status/control words on the data bus.
module xps2_ctrl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    input  logic              data_sel,
    input  logic              data_we,
    input  logic [1:0]        data_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              not_empty,
    output logic              overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            skip_q, skip_d;
    logic                  ev_push;
    logic [9:0]            ev_data;

    logic [9:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  not_empty_q;
    logic                  overflow_q, overflow_d;

    logic                  pop, push, drop, flush, ovf_clr, full, empty;
    logic [7:0]            count_b;
    logic                  unused_data;

    assign full    = count_q[DEPTH_LOG2];
    assign empty   = (count_q == '0);
    assign pop     = data_sel && !data_we && (data_addr == 2'd0) && !empty;
    assign ovf_clr = data_sel && data_we && (data_addr == 2'd1) && data_in[0];
    assign flush   = data_sel && data_we && (data_addr == 2'd2) && data_in[0];
    // A full FIFO still accepts an event when the head is popped in the same cycle.
    assign push    = ev_push && !flush && (!full || pop);
    assign drop    = ev_push && !flush && full && !pop;
    assign count_b = 8'(count_q);
    assign unused_data = ^data_in[DATA_W-1:1];

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_push = 1'b0;
        ev_data = {2'b00, byte_in};
        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (byte_in == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end else begin
                        ev_push = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (byte_in != 8'hE0) begin
                        ev_push = 1'b1;
                        ev_data = {2'b10, byte_in};
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (byte_in != 8'hF0) begin
                        ev_push = 1'b1;
                        ev_data = {2'b01, byte_in};
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    ev_push = 1'b1;
                    ev_data = {2'b11, byte_in};
                    state_d = S_IDLE;
                end
                S_SKIP: begin
                    // The pause sequence carries seven trailing bytes; the last one emits E1 once.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        ev_push = 1'b1;
                        ev_data = {2'b00, 8'hE1};
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (flush) begin
            state_d = S_IDLE;
            skip_d  = '0;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            skip_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_empty_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            not_empty_q <= (count_d != '0);
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev_data;
    end

    always_comb begin
        data_out = '0;
        case (data_addr)
            2'd0:    if (not_empty_q) data_out[10:0] = {1'b1, mem_q[rd_ptr_q]};
            2'd1:    data_out[15:0] = {count_b, 5'b0, overflow_q, full, empty};
            default: data_out = '0;
        endcase
    end

    assign not_empty = not_empty_q;
    assign overflow  = overflow_q;

endmodule
